boot_loader: RTL

//   Hardware loader for the pipelined CPU. It accepts a byte stream over a valid/ready

---
 rtl/boot_loader.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses LOAD/RUN frames from the host link, writes
// 32-bit words into instruction or data memory, then releases the CPU.
module boot_loader #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 8,
  parameter int ADDR_W     = 8
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              cpu_start_o,
  output logic              busy_o,
  output logic              error_o
);

  // state    | meaning
  // ---------+---------------------------------------------------
  // ST_IDLE  | waiting for a frame header (0xA5 load, 0x5A run)
  // ST_TGT   | waiting for target byte (0x00 imem, 0x01 dmem)
  // ST_LEN0  | waiting for low byte of word count
  // ST_LEN1  | waiting for high byte; zero/oversize checked here
  // ST_DATA  | assembling a little-endian word from 4 bytes
  // ST_WRITE | one-cycle memory write strobe, link stalled
  // ST_RUN   | CPU released, loader locked until reset
  // ST_ERR   | sticky protocol error, loader locked until reset
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TGT,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_RUN,
    ST_ERR
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'hA5;
  localparam logic [7:0] CMD_RUN  = 8'h5A;

  state_t state_q, state_d;

  logic              tgt_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [15:0]       wr_cnt_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_data_q;

  logic        rx_fire;
  logic [15:0] len_full;
  logic [31:0] depth_sel;
  logic        len_too_big;
  logic        last_byte;
  logic        last_word;

  assign rx_fire     = rx_valid_i & rx_ready_o;
  assign len_full    = {rx_data_i, len_lo_q};
  assign depth_sel   = tgt_q ? 32'(DMEM_WORDS) : 32'(IMEM_WORDS);
  assign len_too_big = 32'(len_full) > depth_sel;
  assign last_byte   = (byte_idx_q == 2'd3);
  assign last_word   = ((wr_cnt_q + 16'd1) == len_q);

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (rx_data_i == CMD_LOAD) begin
            state_d = ST_TGT;
          end else if (rx_data_i == CMD_RUN) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_TGT: begin
        if (rx_fire) begin
          state_d = (rx_data_i[7:1] == 7'd0) ? ST_LEN0 : ST_ERR;
        end
      end
      ST_LEN0: begin
        if (rx_fire) begin
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (rx_fire) begin
          if (len_full == 16'd0) begin
            state_d = ST_IDLE;
          end else if (len_too_big) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_fire && last_byte) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = last_word ? ST_IDLE : ST_DATA;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  always_comb begin
    rx_ready_o  = 1'b0;
    busy_o      = 1'b1;
    cpu_start_o = 1'b0;
    error_o     = 1'b0;
    imem_we_o   = 1'b0;
    dmem_we_o   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      ST_TGT, ST_LEN0, ST_LEN1, ST_DATA: begin
        rx_ready_o = 1'b1;
      end
      ST_WRITE: begin
        imem_we_o = ~tgt_q;
        dmem_we_o = tgt_q;
      end
      ST_RUN: begin
        busy_o      = 1'b0;
        cpu_start_o = 1'b1;
      end
      ST_ERR: begin
        error_o = 1'b1;
      end
      default: begin
        error_o = 1'b1;
      end
    endcase
  end

  // Write address/data live in their own registers so they hold steady
  // between strobes while the running address advances underneath.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      tgt_q      <= 1'b0;
      len_lo_q   <= 8'd0;
      len_q      <= 16'd0;
      wr_cnt_q   <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= 32'd0;
    end else begin
      unique case (state_q)
        ST_TGT: begin
          if (rx_fire) begin
            tgt_q <= rx_data_i[0];
          end
        end
        ST_LEN0: begin
          if (rx_fire) begin
            len_lo_q <= rx_data_i;
          end
        end
        ST_LEN1: begin
          if (rx_fire) begin
            len_q      <= len_full;
            wr_cnt_q   <= 16'd0;
            addr_q     <= '0;
            byte_idx_q <= 2'd0;
          end
        end
        ST_DATA: begin
          if (rx_fire) begin
            word_q     <= {rx_data_i, word_q[23:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (last_byte) begin
              mem_data_q <= {rx_data_i, word_q};
              mem_addr_q <= addr_q;
            end
          end
        end
        ST_WRITE: begin
          addr_q   <= addr_q + ADDR_W'(1);
          wr_cnt_q <= wr_cnt_q + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

endmodule
